// File: rtl/round_stage_pkg.sv
// Shared definitions for the FMA rounding/packing stage: rounding-mode codes
// and IEEE single-precision limit encodings.
package round_stage_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    localparam int          EXP_MAX    = 255;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
    localparam logic [30:0] INF        = 31'h7F800000;

endpackage

// File: rtl/round_stage_round_incr.sv
// Rounding-increment decision from sign, rounding mode and the L/G/R/S bits.
module round_incr
    import round_stage_pkg::*;
(
    input  logic       sign,
    input  logic [1:0] rm,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    output logic       inc,
    output logic       nx_raw
);

    always_comb begin
        nx_raw = g | r | s;
        case (rm_e'(rm))
            RM_RNE:  inc = g & (r | s | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & nx_raw;
            default: inc = sign & nx_raw;
        endcase
    end

endmodule

// File: rtl/round_stage.sv
// Rounding/packing stage of the FMA datapath: stage 1 rounds the mantissa,
// stage 2 packs the IEEE single result and flags; valid/ready between stages.
module round_stage
    import round_stage_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        rm,
    input  logic              s_final,
    input  logic [EXP_W-1:0]  exp_norm,
    input  logic [FRAC_W-1:0] frac_inter_norm,
    input  logic              zero_m,
    input  logic              denorm_m,
    input  logic              special_m,
    input  logic [31:0]       special_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_of,
    output logic              flag_uf,
    output logic              flag_nx
);

    localparam int MW = FRAC_W - 2;

    logic             s1_valid;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_mant;
    logic             s1_nx;
    rm_e              s1_rm;
    logic             s1_zero;
    logic             s1_denorm;
    logic             s1_special;
    logic [31:0]      s1_special_res;

    logic          s2_adv;
    logic          s1_adv;
    logic          accept;
    logic          inc;
    logic          nx_raw;
    logic [MW-1:0] mant_rnd;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = ~s1_valid | s2_adv;
    assign accept   = in_valid & in_ready;

    round_incr u_round_incr (
        .sign   (s_final),
        .rm     (rm),
        .lsb    (frac_inter_norm[3]),
        .g      (frac_inter_norm[2]),
        .r      (frac_inter_norm[1]),
        .s      (frac_inter_norm[0]),
        .inc    (inc),
        .nx_raw (nx_raw)
    );

    assign mant_rnd = {1'b0, frac_inter_norm[FRAC_W-1:3]} + MW'(inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_mant        <= '0;
            s1_nx          <= 1'b0;
            s1_rm          <= RM_RNE;
            s1_zero        <= 1'b0;
            s1_denorm      <= 1'b0;
            s1_special     <= 1'b0;
            s1_special_res <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_sign        <= s_final;
                s1_exp         <= exp_norm;
                s1_mant        <= mant_rnd;
                s1_nx          <= nx_raw;
                s1_rm          <= rm_e'(rm);
                s1_zero        <= zero_m;
                s1_denorm      <= denorm_m;
                s1_special     <= special_m;
                s1_special_res <= special_res;
            end
        end
    end

    logic               carry;
    logic signed [EXP_W:0] exp_adj;
    logic [7:0]         exp_field;
    logic [22:0]        mant_out;
    logic               ovf;
    logic               to_inf;
    logic [31:0]        pack_res;
    logic               pack_of;
    logic               pack_uf;
    logic               pack_nx;

    always_comb begin
        carry   = s1_mant[MW-1];
        exp_adj = {s1_exp[EXP_W-1], s1_exp} + {{EXP_W{1'b0}}, carry};
        ovf     = ~s1_denorm & (exp_adj >= $signed((EXP_W+1)'(EXP_MAX)));
        to_inf  = (s1_rm == RM_RNE) | ((s1_rm == RM_RUP) & ~s1_sign)
                | ((s1_rm == RM_RDN) & s1_sign);

        // A subnormal that rounds up into bit 23 becomes the smallest normal.
        if (s1_denorm) begin
            exp_field = {7'b0, s1_mant[23]};
            mant_out  = s1_mant[22:0];
        end else if (carry) begin
            exp_field = exp_adj[7:0];
            mant_out  = s1_mant[23:1];
        end else begin
            exp_field = exp_adj[7:0];
            mant_out  = s1_mant[22:0];
        end

        pack_of = 1'b0;
        pack_uf = 1'b0;
        pack_nx = 1'b0;
        if (s1_special) begin
            pack_res = s1_special_res;
        end else if (s1_zero) begin
            pack_res = {s1_sign, 31'b0};
        end else if (ovf) begin
            pack_res = {s1_sign, to_inf ? INF : MAX_FINITE};
            pack_of  = 1'b1;
            pack_nx  = 1'b1;
        end else begin
            pack_res = {s1_sign, exp_field, mant_out};
            pack_nx  = s1_nx;
            pack_uf  = s1_denorm & s1_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_of   <= 1'b0;
            flag_uf   <= 1'b0;
            flag_nx   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_adv) begin
                result  <= pack_res;
                flag_of <= pack_of;
                flag_uf <= pack_uf;
                flag_nx <= pack_nx;
            end
        end
    end

endmodule
